bus_master: RTL and testbench

- Initiator end of the on-chip valid/ready bus used by the memory and peripheral slaves.
- Accepts single-beat load/store requests from the CPU core and drives one bus transfer per request.
- Returns read data or a write acknowledge to the core.
- Adds alignment checking and a watchdog timeout, so an unmapped or stalled slave produces an error response instead of hanging the core.

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_watchdog.sv | 31 +++
 rtl/bus_master.sv | 110 +++++++++++
 tb/tb_bus_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the on-chip valid/ready bus: mode encoding,
// initiator state encoding and default widths.
package bus_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;

   localparam logic BUS_MODE_READ  = 1'b0;
   localparam logic BUS_MODE_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } master_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// Transfer watchdog: counts stalled cycles and flags expiry when the count
// reaches TIMEOUT-1. TIMEOUT = 0 disables expiry.
module bus_watchdog #(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int              LIMIT_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TO_W-1:0] LIMIT   = LIMIT_I[TO_W-1:0];

   logic [TO_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/bus_master.sv
// Initiator end of the valid/ready bus: one transfer per core request, with
// alignment check and watchdog abort turning bad accesses into error responses.
module bus_master
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int TIMEOUT    = 64,
   parameter int TO_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] BUS_addr,
   output logic [DATA_WIDTH-1:0] BUS_wdata,
   input  logic [DATA_WIDTH-1:0] BUS_rdata,
   output logic                  BUS_valid,
   input  logic                  BUS_wready,
   output logic                  BUS_rready,
   input  logic                  BUS_rvalid,
   output logic                  BUS_mode
);

   master_state_t state;
   logic          accept;
   logic          misaligned;
   logic          complete;
   logic          wd_enable;
   logic          expire;

   assign accept     = req_valid && req_ready;
   assign misaligned = (req_addr[1:0] != 2'b00);
   // Slave handshakes only count in the matching state; stray strobes are ignored.
   assign complete   = BUS_valid &&
                       (((state == WRITE) && BUS_wready) ||
                        ((state == READ) && BUS_rvalid && BUS_rready));
   assign wd_enable  = (state != IDLE) && !complete;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (wd_enable),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         BUS_addr   <= '0;
         BUS_wdata  <= '0;
         BUS_valid  <= 1'b0;
         BUS_rready <= 1'b0;
         BUS_mode   <= BUS_MODE_READ;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  if (misaligned) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     BUS_addr   <= req_addr;
                     BUS_wdata  <= req_write ? req_wdata : '0;
                     BUS_mode   <= req_write ? BUS_MODE_WRITE : BUS_MODE_READ;
                     BUS_valid  <= 1'b1;
                     BUS_rready <= !req_write;
                     state      <= req_write ? WRITE : READ;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WRITE, READ: begin
               // Completion wins over an expiry on the same edge.
               if (complete || expire) begin
                  state      <= IDLE;
                  BUS_valid  <= 1'b0;
                  BUS_rready <= 1'b0;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b1;
                  resp_err   <= !complete;
                  resp_rdata <= (complete && (state == READ)) ? BUS_rdata : '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master.sv
// Directed plus randomized bench for bus_master with TIMEOUT = 8; responses
// are checked against a queue of expected {err, rdata} values.
module tb_bus_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;
   logic [AW-1:0] BUS_addr;
   logic [DW-1:0] BUS_wdata;
   logic [DW-1:0] BUS_rdata;
   logic          BUS_valid;
   logic          BUS_wready;
   logic          BUS_rready;
   logic          BUS_rvalid;
   logic          BUS_mode;

   int checks = 0;
   int errors = 0;
   logic [DW:0] exp_q[$];
   logic [DW:0] mon_exp;

   bus_master #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TO),
      .TO_W       (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .BUS_addr   (BUS_addr),
      .BUS_wdata  (BUS_wdata),
      .BUS_rdata  (BUS_rdata),
      .BUS_valid  (BUS_valid),
      .BUS_wready (BUS_wready),
      .BUS_rready (BUS_rready),
      .BUS_rvalid (BUS_rvalid),
      .BUS_mode   (BUS_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            check("resp_unexpected", 64'(resp_valid), 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("resp_err", 64'(resp_err), 64'(mon_exp[DW]));
            check("resp_rdata", 64'(resp_rdata), 64'(mon_exp[DW-1:0]));
         end
      end
   end

   // delay < 0: slave never responds. Otherwise the slave completes in
   // valid cycle delay+1. noise drives the handshake the current mode ignores.
   task automatic run_xfer(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int delay, input bit noise, input string tag);
      logic          mis;
      logic          err;
      logic [DW-1:0] exp_rdata;
      int            exp_n;
      int            n;
      logic          hit;
      mis       = (addr[1:0] != 2'b00);
      err       = mis || (delay < 0) || (delay >= TO);
      exp_rdata = (!err && !wr) ? rdata : '0;
      exp_n     = mis ? 0 : ((delay < 0 || delay >= TO) ? TO : delay + 1);
      check({tag, "_req_ready_in"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      exp_q.push_back({err, exp_rdata});
      tick();
      req_valid = 1'b0;
      req_wdata = $urandom;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid) break;
         if (BUS_valid) begin
            n++;
            check({tag, "_bus_mode"}, 64'(BUS_mode), 64'(wr));
            check({tag, "_bus_addr"}, 64'(BUS_addr), 64'(addr));
            check({tag, "_bus_wdata"}, 64'(BUS_wdata), wr ? 64'(wdata) : 64'd0);
            check({tag, "_bus_rready"}, 64'(BUS_rready), 64'(!wr));
         end
         check({tag, "_req_ready_busy"}, 64'(req_ready), 64'd0);
         hit = BUS_valid && (delay >= 0) && (n == delay + 1);
         if (wr) begin
            BUS_wready = hit;
            BUS_rvalid = noise;
         end else begin
            BUS_rvalid = hit;
            BUS_wready = noise;
         end
         BUS_rdata = hit ? rdata : $urandom;
         tick();
      end
      BUS_wready = 1'b0;
      BUS_rvalid = 1'b0;
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_valid_cycles"}, 64'(n), 64'(exp_n));
      check({tag, "_bus_valid_done"}, 64'(BUS_valid), 64'd0);
      check({tag, "_bus_rready_done"}, 64'(BUS_rready), 64'd0);
      check({tag, "_req_ready_resp"}, 64'(req_ready), 64'(!mis));
      if (mis) tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      BUS_rdata  = '0;
      BUS_wready = 1'b0;
      BUS_rvalid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_err", 64'(resp_err), 64'd0);
      check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      check("rst_bus_valid", 64'(BUS_valid), 64'd0);
      check("rst_bus_rready", 64'(BUS_rready), 64'd0);
      check("rst_bus_mode", 64'(BUS_mode), 64'd0);
      check("rst_bus_addr", 64'(BUS_addr), 64'd0);
      check("rst_bus_wdata", 64'(BUS_wdata), 64'd0);

      run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0, "wr_zero_wait");
      run_xfer(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0, "rd_wait3");
      run_xfer(1'b0, 32'h13, 32'h0, 32'h0, 0, 1'b0, "rd_misaligned");
      run_xfer(1'b1, 32'h22, 32'h5555AAAA, 32'h0, 0, 1'b0, "wr_misaligned");
      run_xfer(1'b0, 32'h40, 32'h0, 32'h12345678, -1, 1'b0, "rd_timeout");
      run_xfer(1'b1, 32'h44, 32'hCAFEF00D, 32'h0, -1, 1'b0, "wr_timeout");
      run_xfer(1'b0, 32'h48, 32'h0, 32'hA5A55A5A, TO - 1, 1'b0, "rd_expiry_edge");
      run_xfer(1'b1, 32'h4C, 32'h0BADF00D, 32'h0, TO - 1, 1'b0, "wr_expiry_edge");

      // Slave strobes while idle must not produce a response.
      BUS_rvalid = 1'b1;
      BUS_wready = 1'b1;
      BUS_rdata  = 32'hFFFF0000;
      tick();
      tick();
      check("idle_noise_resp", 64'(resp_valid), 64'd0);
      check("idle_noise_bus_valid", 64'(BUS_valid), 64'd0);
      BUS_rvalid = 1'b0;
      BUS_wready = 1'b0;

      for (int k = 0; k < 8; k++) begin
         run_xfer(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                  $urandom, $urandom, int'($urandom_range(0, 5)), 1'b1, "rand");
      end

      // Asynchronous reset in the middle of a read.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h80;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      check("abort_bus_valid_before", 64'(BUS_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_bus_valid", 64'(BUS_valid), 64'd0);
      check("abort_bus_rready", 64'(BUS_rready), 64'd0);
      check("abort_req_ready", 64'(req_ready), 64'd1);
      check("abort_resp_valid", 64'(resp_valid), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_abort_resp_valid", 64'(resp_valid), 64'd0);
         check("post_abort_req_ready", 64'(req_ready), 64'd1);
      end

      run_xfer(1'b0, 32'h84, 32'h0, 32'h600DCAFE, 1, 1'b0, "rd_after_reset");

      tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
